pc_sequencer: RTL

//   Fetch/branch controller for the 8-bit program counter. Sequences PC clear, advance, hold and

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_sequencer_if.sv | 26 ++
 rtl/pc_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter fetch/branch sequencer.
package pc_seq_pkg;

  localparam int SEQ_PC_W     = 8;
  localparam int SEQ_CNT_W    = 16;
  localparam int SEQ_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_HALTED = 2'b10,
    ST_FAULT  = 2'b11
  } seq_state_t;

  // PC command encodings: pc_next = pc + 1 + (mask & ofs).
  // HOLD relies on 1 + all-ones wrapping to zero.
  localparam logic [7:0] CMD_HOLD_MASK = 8'hFF;
  localparam logic [7:0] CMD_HOLD_OFS  = 8'hFF;
  localparam logic [7:0] CMD_ADV       = 8'h00;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the sequencer, the instruction memory / decode side and the PC.
interface pc_sequencer_if #(
  parameter int PC_W = 8
);

  logic            imem_req;
  logic            imem_ack;
  logic            stall;
  logic            halt;
  logic            branch_taken;
  logic [PC_W-1:0] branch_offset;
  logic            pc_startup;
  logic [PC_W-1:0] pc_control;
  logic [PC_W-1:0] jump_offset;

  modport master (
    output imem_req, pc_startup, pc_control, jump_offset,
    input  imem_ack, stall, halt, branch_taken, branch_offset
  );

  modport slave (
    input  imem_req, pc_startup, pc_control, jump_offset,
    output imem_ack, stall, halt, branch_taken, branch_offset
  );

endinterface

// File: rtl/pc_sequencer.sv
// Fetch/branch controller driving the program counter command inputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | PC held in clear, no fetch, retired count cleared
// FETCH   | requesting imem at pc; advance / branch / hold per accept
// HALTED  | HALT retired, PC frozen until run drops
// FAULT   | imem never acked within MAX_WAIT cycles, PC frozen
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W     = SEQ_PC_W,
  parameter int CNT_W    = SEQ_CNT_W,
  parameter int MAX_WAIT = SEQ_MAX_WAIT
) (
  input  logic                 clk,
  input  logic                 startup_n,
  input  logic                 run,
  pc_sequencer_if.master       bus,
  output logic [1:0]           state,
  output logic                 fault,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  seq_state_t state_q;
  logic [7:0] wait_cnt;
  logic       accept;

  // Command widths follow PC_W; each command bit pattern is uniform.
  logic [PC_W-1:0] hold_mask;
  logic [PC_W-1:0] hold_ofs;
  logic [PC_W-1:0] adv_cmd;

  assign hold_mask = {PC_W{CMD_HOLD_MASK[0]}};
  assign hold_ofs  = {PC_W{CMD_HOLD_OFS[0]}};
  assign adv_cmd   = {PC_W{CMD_ADV[0]}};

  assign accept = (state_q == ST_FETCH) & bus.imem_ack & ~bus.stall;
  assign state  = state_q;
  assign fault  = (state_q == ST_FAULT);

  // PC command and fetch request, decoded from registered state so that an
  // async reset drops imem_req and forces pc_startup without waiting a clock.
  always_comb begin
    bus.pc_startup  = 1'b0;
    bus.imem_req    = 1'b0;
    bus.pc_control  = adv_cmd;
    bus.jump_offset = adv_cmd;
    unique case (state_q)
      ST_IDLE: begin
        bus.pc_startup = 1'b1;
      end
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (accept && !bus.halt && bus.branch_taken) begin
          bus.pc_control  = hold_mask;
          bus.jump_offset = bus.branch_offset;
        end else if (accept && !bus.halt) begin
          bus.pc_control  = adv_cmd;
          bus.jump_offset = adv_cmd;
        end else begin
          bus.pc_control  = hold_mask;
          bus.jump_offset = hold_ofs;
        end
      end
      default: begin
        bus.pc_control  = hold_mask;
        bus.jump_offset = hold_ofs;
      end
    endcase
  end

  // Sequencer state, fetch-timeout counter and retired-instruction counter.
  always_ff @(posedge clk or negedge startup_n) begin
    if (!startup_n) begin
      state_q  <= ST_IDLE;
      wait_cnt <= 8'd0;
      retired  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          wait_cnt <= 8'd0;
          retired  <= '0;
          if (run) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (accept) retired <= retired + CNT_W'(1);
          // A present ack, even if stalled, proves imem is alive.
          if (bus.imem_ack) begin
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= 8'd0;
            state_q  <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          if (accept && bus.halt) state_q <= ST_HALTED;
        end
        ST_HALTED, ST_FAULT: begin
          wait_cnt <= 8'd0;
          if (!run) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
